// File: rtl/fp_mult_pipe.sv
// Four-stage pipelined IEEE-754 multiplier (RNE, flush-to-zero, valid/ready with tag).
// Define FP_MULT_RND_MODE_EN to add the rnd_mode input (RNE/RTZ/+Inf/-Inf).
module fp_mult_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  parameter int unsigned TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  input  logic [TAG_W-1:0]       in_tag,
`ifdef FP_MULT_RND_MODE_EN
  input  logic [1:0]             rnd_mode,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic [TAG_W-1:0]       out_tag,
  output logic [3:0]             flags
);

  localparam int unsigned W      = EXP_W + MAN_W + 1;
  localparam int unsigned SIG_W  = MAN_W + 1;
  localparam int unsigned PROD_W = 2 * SIG_W;
  localparam int unsigned XW     = EXP_W + 2;
  localparam logic [XW-1:0]    BIAS_X    = XW'(2**(EXP_W-1) - 1);
  localparam logic [XW-1:0]    EXP_MAX_X = XW'(2**EXP_W - 1);
  localparam logic [EXP_W-1:0] EXP_ONES  = '1;
  localparam logic [W-1:0]     QNAN      = {1'b0, EXP_ONES, 1'b1, (MAN_W-1)'(0)};

  logic w_adv;
  logic [1:0] w_mode_in;

`ifdef FP_MULT_RND_MODE_EN
  assign w_mode_in = rnd_mode;
`else
  assign w_mode_in = 2'b00;
`endif

  // Every stage holds while the output register is blocked.
  assign w_adv    = ~(out_valid & ~out_ready);
  assign in_ready = w_adv;

  // S1: unpack and classify
  logic [EXP_W-1:0] w_ea, w_eb;
  logic [MAN_W-1:0] w_fa, w_fb;
  logic w_nan_a, w_nan_b, w_snan_a, w_snan_b, w_inf_a, w_inf_b, w_zero_a, w_zero_b;

  assign w_ea     = a[MAN_W +: EXP_W];
  assign w_eb     = b[MAN_W +: EXP_W];
  assign w_fa     = a[MAN_W-1:0];
  assign w_fb     = b[MAN_W-1:0];
  assign w_nan_a  = (&w_ea) & (|w_fa);
  assign w_nan_b  = (&w_eb) & (|w_fb);
  assign w_snan_a = w_nan_a & ~w_fa[MAN_W-1];
  assign w_snan_b = w_nan_b & ~w_fb[MAN_W-1];
  assign w_inf_a  = (&w_ea) & ~(|w_fa);
  assign w_inf_b  = (&w_eb) & ~(|w_fb);
  assign w_zero_a = ~(|w_ea);
  assign w_zero_b = ~(|w_eb);

  logic r_v1, r_sign1, r_nan1, r_snan1, r_ixz1, r_inf1, r_zero1;
  logic [SIG_W-1:0] r_ma1, r_mb1;
  logic [XW-1:0]    r_exp1;
  logic [TAG_W-1:0] r_tag1;
  logic [1:0]       r_mode1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_v1 <= 1'b0; r_sign1 <= 1'b0; r_nan1 <= 1'b0; r_snan1 <= 1'b0;
      r_ixz1 <= 1'b0; r_inf1 <= 1'b0; r_zero1 <= 1'b0;
      r_ma1 <= '0; r_mb1 <= '0; r_exp1 <= '0; r_tag1 <= '0; r_mode1 <= 2'b00;
    end else if (w_adv) begin
      r_v1    <= in_valid;
      r_sign1 <= a[W-1] ^ b[W-1];
      r_nan1  <= w_nan_a | w_nan_b;
      r_snan1 <= w_snan_a | w_snan_b;
      r_ixz1  <= (w_inf_a & w_zero_b) | (w_zero_a & w_inf_b);
      r_inf1  <= w_inf_a | w_inf_b;
      r_zero1 <= w_zero_a | w_zero_b;
      r_ma1   <= {1'b1, w_fa};
      r_mb1   <= {1'b1, w_fb};
      r_exp1  <= XW'(w_ea) + XW'(w_eb) - BIAS_X;
      r_tag1  <= in_tag;
      r_mode1 <= w_mode_in;
    end
  end

  // S2: full significand product
  logic r_v2, r_sign2, r_nan2, r_snan2, r_ixz2, r_inf2, r_zero2;
  logic [PROD_W-1:0] r_prod2;
  logic [XW-1:0]     r_exp2;
  logic [TAG_W-1:0]  r_tag2;
  logic [1:0]        r_mode2;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_v2 <= 1'b0; r_sign2 <= 1'b0; r_nan2 <= 1'b0; r_snan2 <= 1'b0;
      r_ixz2 <= 1'b0; r_inf2 <= 1'b0; r_zero2 <= 1'b0;
      r_prod2 <= '0; r_exp2 <= '0; r_tag2 <= '0; r_mode2 <= 2'b00;
    end else if (w_adv) begin
      r_v2 <= r_v1; r_sign2 <= r_sign1; r_nan2 <= r_nan1; r_snan2 <= r_snan1;
      r_ixz2 <= r_ixz1; r_inf2 <= r_inf1; r_zero2 <= r_zero1;
      r_prod2 <= PROD_W'(r_ma1) * PROD_W'(r_mb1);
      r_exp2  <= r_exp1; r_tag2 <= r_tag1; r_mode2 <= r_mode1;
    end
  end

  // S3: product lies in [1,4), so normalise by at most one bit
  logic w_hi;
  assign w_hi = r_prod2[PROD_W-1];

  logic r_v3, r_sign3, r_nan3, r_snan3, r_ixz3, r_inf3, r_zero3, r_g3, r_r3, r_s3;
  logic [SIG_W-1:0] r_mant3;
  logic [XW-1:0]    r_exp3;
  logic [TAG_W-1:0] r_tag3;
  logic [1:0]       r_mode3;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_v3 <= 1'b0; r_sign3 <= 1'b0; r_nan3 <= 1'b0; r_snan3 <= 1'b0;
      r_ixz3 <= 1'b0; r_inf3 <= 1'b0; r_zero3 <= 1'b0;
      r_g3 <= 1'b0; r_r3 <= 1'b0; r_s3 <= 1'b0;
      r_mant3 <= '0; r_exp3 <= '0; r_tag3 <= '0; r_mode3 <= 2'b00;
    end else if (w_adv) begin
      r_v3 <= r_v2; r_sign3 <= r_sign2; r_nan3 <= r_nan2; r_snan3 <= r_snan2;
      r_ixz3 <= r_ixz2; r_inf3 <= r_inf2; r_zero3 <= r_zero2;
      r_mant3 <= w_hi ? r_prod2[PROD_W-1 -: SIG_W] : r_prod2[PROD_W-2 -: SIG_W];
      r_g3    <= w_hi ? r_prod2[MAN_W]   : r_prod2[MAN_W-1];
      r_r3    <= w_hi ? r_prod2[MAN_W-1] : r_prod2[MAN_W-2];
      r_s3    <= w_hi ? (|r_prod2[MAN_W-2:0]) : (|r_prod2[MAN_W-3:0]);
      r_exp3  <= r_exp2 + XW'(w_hi);
      r_tag3  <= r_tag2; r_mode3 <= r_mode2;
    end
  end

  // S4: round, range check, special-case override
  logic w_any, w_inc, w_carry, w_ovf, w_unf, w_sat;
  logic [SIG_W:0]   w_sum;
  logic [MAN_W-1:0] w_frac;
  logic [XW-1:0]    w_exp_r;
  logic [W-1:0]     w_res;
  logic [3:0]       w_flg;

  assign w_any = r_g3 | r_r3 | r_s3;

  always_comb begin
    w_inc = 1'b0;
    case (r_mode3)
      2'b00:   w_inc = r_g3 & (r_r3 | r_s3 | r_mant3[0]);
      2'b01:   w_inc = 1'b0;
      2'b10:   w_inc = w_any & ~r_sign3;
      default: w_inc = w_any & r_sign3;
    endcase
  end

  assign w_sum   = {1'b0, r_mant3} + (SIG_W+1)'(w_inc);
  assign w_carry = w_sum[SIG_W];
  assign w_frac  = w_carry ? w_sum[MAN_W:1] : w_sum[MAN_W-1:0];
  assign w_exp_r = r_exp3 + XW'(w_carry);
  assign w_ovf   = ~w_exp_r[XW-1] & (w_exp_r >= EXP_MAX_X);
  assign w_unf   = w_exp_r[XW-1] | (w_exp_r == '0);
  assign w_sat   = (r_mode3 == 2'b01) | ((r_mode3 == 2'b10) & r_sign3) |
                   ((r_mode3 == 2'b11) & ~r_sign3);

  always_comb begin
    w_res = {r_sign3, w_exp_r[EXP_W-1:0], w_frac};
    w_flg = {3'b000, w_any};
    if (r_nan3) begin
      w_res = QNAN;
      w_flg = {r_snan3, 3'b000};
    end else if (r_ixz3) begin
      w_res = QNAN;
      w_flg = 4'b1000;
    end else if (r_inf3) begin
      w_res = {r_sign3, EXP_ONES, MAN_W'(0)};
      w_flg = 4'b0000;
    end else if (r_zero3) begin
      w_res = {r_sign3, (W-1)'(0)};
      w_flg = 4'b0000;
    end else if (w_ovf) begin
      w_res = w_sat ? {r_sign3, EXP_ONES - EXP_W'(1), {MAN_W{1'b1}}}
                    : {r_sign3, EXP_ONES, MAN_W'(0)};
      w_flg = 4'b0101;
    end else if (w_unf) begin
      w_res = {r_sign3, (W-1)'(0)};
      w_flg = 4'b0011;
    end
  end

  logic             r_out_valid;
  logic [W-1:0]     r_result;
  logic [TAG_W-1:0] r_out_tag;
  logic [3:0]       r_flags;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_out_valid <= 1'b0; r_result <= '0; r_out_tag <= '0; r_flags <= 4'b0000;
    end else if (w_adv) begin
      r_out_valid <= r_v3;
      r_result    <= w_res;
      r_out_tag   <= r_tag3;
      r_flags     <= w_flg;
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign out_tag   = r_out_tag;
  assign flags     = r_flags;

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Scoreboard bench for fp_mult_pipe (fp32, default RNE build): directed, backpressure, random, reset.
module tb_fp_mult_pipe;

  localparam int unsigned EXP_W = 8;
  localparam int unsigned MAN_W = 23;
  localparam int unsigned TAG_W = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [3:0]  out_tag;
  logic [3:0]  flags;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  tag;
    logic [3:0]  flg;
    int          stamp;
    bit          chk_lat;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          acc_cnt = 0;
  bit          directed = 1'b0;
  bit          chk_lat_next = 1'b0;
  logic [35:0] exp_next = '0;
  bit          rnd_done = 1'b0;

  fp_mult_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .out_tag(out_tag), .flags(flags)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: exact integer product, rounded by comparing the remainder to half an ulp.
  function automatic logic [35:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    logic s;
    int ex, ey, e, sh;
    logic [22:0] fx, fy;
    bit nx, ny, snx, sny, ix, iy, zx, zy;
    longint unsigned p, q, rem, half;
    s  = x[31] ^ y[31];
    ex = int'(x[30:23]); ey = int'(y[30:23]);
    fx = x[22:0]; fy = y[22:0];
    nx = (ex == 255) && (fx != 0); ny = (ey == 255) && (fy != 0);
    snx = nx && !fx[22]; sny = ny && !fy[22];
    ix = (ex == 255) && (fx == 0); iy = (ey == 255) && (fy == 0);
    zx = (ex == 0); zy = (ey == 0);
    if (nx || ny) return {snx || sny, 3'b000, 32'h7FC00000};
    if ((ix && zy) || (zx && iy)) return {4'b1000, 32'h7FC00000};
    if (ix || iy) return {4'b0000, s, 8'hFF, 23'h0};
    if (zx || zy) return {4'b0000, s, 31'h0};
    p = 64'({1'b1, fx}) * 64'({1'b1, fy});
    e = ex + ey - 127;
    if (p >= (64'd1 << 47)) begin sh = 24; e++; end
    else sh = 23;
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q++;
    if (q == (64'd1 << 24)) begin q = q >> 1; e++; end
    if (e >= 255) return {4'b0101, s, 8'hFF, 23'h0};
    if (e <= 0) return {4'b0011, s, 31'h0};
    return {3'b000, rem != 0, s, 8'(e), q[22:0]};
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [31:0] r;
    int unsigned k;
    r = $urandom;
    k = $urandom_range(0, 15);
    case (k)
      0: begin
        case ($urandom_range(0, 7))
          0: return 32'h00000000;
          1: return 32'h80000000;
          2: return 32'h7F800000;
          3: return 32'hFF800000;
          4: return 32'h7FC00000;
          5: return 32'h7F800001;
          6: return {r[31], 8'h00, r[22:0]};
          default: return 32'h3F800000;
        endcase
      end
      1: return r;
      2: return {r[31], 8'd100 + 8'(r[29:24]), 23'h7FFFFF};
      3: return {r[31], 8'd100 + 8'(r[29:24]), r[22:12], 12'h000};
      4: return {r[31], (r[30] ? 8'd200 : 8'd1) + 8'(r[27:23]), r[22:0]};
      default: return {r[31], 8'd64 + 8'(r[29:23]), r[22:0]};
    endcase
  endfunction

  // Monitor: push on input handshake, pop/compare on output handshake, check hold under stall.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_res;
  logic [3:0]  prev_tag, prev_flg;
  always @(negedge clk) begin
    exp_t e, g;
    logic [35:0] m;
    if (!rstn) begin
      prev_stall = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        m = directed ? exp_next : ref_mul(a, b);
        e.res = m[31:0]; e.flg = m[35:32]; e.tag = in_tag;
        e.stamp = cyc + 1; e.chk_lat = directed && chk_lat_next;
        sb.push_back(e);
        acc_cnt++;
      end
      if (prev_stall && out_valid) begin
        checks++;
        if (result !== prev_res || out_tag !== prev_tag || flags !== prev_flg) begin
          errors++;
          $display("FAIL hold_under_stall got res=%h tag=%0d flags=%b required res=%h tag=%0d flags=%b",
                   result, out_tag, flags, prev_res, prev_tag, prev_flg);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output got res=%h tag=%0d required no output", result, out_tag);
        end else begin
          g = sb.pop_front();
          if (result !== g.res || out_tag !== g.tag || flags !== g.flg) begin
            errors++;
            $display("FAIL result got res=%h tag=%0d flags=%b required res=%h tag=%0d flags=%b",
                     result, out_tag, flags, g.res, g.tag, g.flg);
          end
          if (g.chk_lat) begin
            checks++;
            if (cyc + 1 - g.stamp != 4) begin
              errors++;
              $display("FAIL latency got %0d required 4", cyc + 1 - g.stamp);
            end
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_res = result; prev_tag = out_tag; prev_flg = flags;
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h required %h", nm, got, want);
    end
  endtask

  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [3:0] t,
                      input bit dir, input logic [35:0] ex, input bit lat);
    int n;
    bit acc;
    @(posedge clk); #1;
    in_valid = 1'b1; a = x; b = y; in_tag = t;
    directed = dir; exp_next = ex; chk_lat_next = lat;
    n = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      n++;
    end while (!acc && n < 200);
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL accept_timeout got in_ready=0 required 1 within 200 cycles tag=%0d", t);
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0; directed = 1'b0; chk_lat_next = 1'b0;
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int c0;
    rstn = 1'b0; in_valid = 1'b0; a = '0; b = '0; in_tag = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_result", 64'(result), 64'd0);
    chk("reset_out_tag", 64'(out_tag), 64'd0);
    chk("reset_flags", 64'(flags), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk) rstn = 1'b1;

    send(32'h3FC00000, 32'h40000000, 4'd3, 1'b1, {4'b0000, 32'h40400000}, 1'b1);
    send(32'h3F800001, 32'h3F800001, 4'd1, 1'b1, {4'b0001, 32'h3F800002}, 1'b0);
    send(32'h7F000000, 32'h40000000, 4'd2, 1'b1, {4'b0101, 32'h7F800000}, 1'b0);
    send(32'h7F800000, 32'h00000000, 4'd4, 1'b1, {4'b1000, 32'h7FC00000}, 1'b0);
    send(32'h00800000, 32'h3F000000, 4'd5, 1'b1, {4'b0011, 32'h00000000}, 1'b0);
    send(32'h80000001, 32'h3F800000, 4'd6, 1'b1, {4'b0000, 32'h80000000}, 1'b0);
    send(32'h7F800001, 32'h3F800000, 4'd7, 1'b1, {4'b1000, 32'h7FC00000}, 1'b0);
    send(32'hFF800000, 32'h40000000, 4'd8, 1'b1, {4'b0000, 32'hFF800000}, 1'b0);
    send(32'h80000000, 32'h40400000, 4'd9, 1'b1, {4'b0000, 32'h80000000}, 1'b0);
    idle();
    drain();

    // Backpressure: with the output blocked the pipe absorbs exactly four operations.
    c0 = acc_cnt;
    @(posedge clk); #1 out_ready = 1'b0;
    fork
      begin
        for (int t = 0; t < 10; t++) send(rnd_op(), rnd_op(), 4'(t), 1'b0, '0, 1'b0);
      end
      begin
        repeat (12) @(negedge clk);
        chk("bp_accepted", 64'(acc_cnt - c0), 64'd4);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    idle();
    drain();

    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          if ($urandom_range(0, 3) == 0) idle();
          send(rnd_op(), rnd_op(), 4'($urandom_range(0, 15)), 1'b0, '0, 1'b0);
        end
        idle();
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();

    // Reset with three operations in flight: nothing may emerge afterwards.
    send(32'h40000000, 32'h40000000, 4'd1, 1'b0, '0, 1'b0);
    send(32'h40400000, 32'h40000000, 4'd2, 1'b0, '0, 1'b0);
    send(32'h40800000, 32'h40000000, 4'd3, 1'b0, '0, 1'b0);
    idle();
    #1 rstn = 1'b0;
    #1;
    chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_result", 64'(result), 64'd0);
    chk("rst_mid_flags", 64'(flags), 64'd0);
    sb.delete();
    @(posedge clk); #3 rstn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rst_no_output", 64'(out_valid), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
